// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART arbiter/distributor
//               blocks. Optional feature macro used by users of this package:
//               UART_ARB_BURST_LIMIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } uart_arb_state_t;

    // Index width for an N-way selector; a 1-way selector still needs one bit.
    function automatic int uart_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Requester-side and TX-FIFO-side signals of uart_tx_arbiter.
//               master = environment (requesters + FIFO), slave = arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    import uart_pkg::*;

    logic [N_REQ-1:0]             req;
    logic [UART_BYTE_W*N_REQ-1:0] data;
    logic [N_REQ-1:0]             last;
    logic [N_REQ-1:0]             ack;
    logic [N_REQ-1:0]             grant;
    logic                         fifo_full;
    logic                         fifo_wr_en;
    logic [UART_BYTE_W-1:0]       fifo_data;
    logic                         busy;
    logic                         pkt_done;

    modport master (
        output req, data, last, fifo_full,
        input  ack, grant, fifo_wr_en, fifo_data, busy, pkt_done
    );

    modport slave (
        input  req, data, last, fifo_full,
        output ack, grant, fifo_wr_en, fifo_data, busy, pkt_done
    );

endinterface
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_pick
// Description : Combinational rotating-priority picker: returns the first
//               asserted request scanning rr_ptr, rr_ptr+1, ... (mod N_REQ).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  wire logic [N_REQ-1:0] req,
    input  wire logic [IDX_W-1:0] rr_ptr,
    output logic                  valid,
    output logic [IDX_W-1:0]      index
);

    always_comb begin
        int               w_pos;
        logic [IDX_W-1:0] w_idx;
        valid = 1'b0;
        index = '0;
        w_pos = 0;
        w_idx = '0;
        // Scan from the farthest offset down so the nearest hit wins last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_pos = int'(rr_ptr) + k;
            if (w_pos >= N_REQ) begin
                w_pos = w_pos - N_REQ;
            end
            w_idx = IDX_W'(w_pos);
            if (req[w_idx]) begin
                valid = 1'b1;
                index = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Packet-atomic round-robin arbiter sharing one UART TX FIFO
//               write port among N_REQ byte-stream requesters.
//               Optional macro UART_ARB_BURST_LIMIT_EN: preempt after
//               MAX_BURST bytes without last.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16
) (
    input wire logic         clk,
    input wire logic         rst_n,
    uart_tx_arbiter_if.slave bus
);

    localparam int IDX_W = uart_idx_w(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_param_check
        $error("uart_tx_arbiter: N_REQ or MAX_BURST out of range");
    end

    uart_arb_state_t  r_state;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [N_REQ-1:0] r_grant;
    logic [7:0]       r_burst_cnt;
    logic             r_pkt_done;

    logic                   w_pick_valid;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_wr_en;
    logic [IDX_W-1:0]       w_next_ptr;
    logic [7:0]             w_burst_next;
    logic [UART_BYTE_W-1:0] w_bytes [N_REQ];

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (bus.req),
        .rr_ptr (r_rr_ptr),
        .valid  (w_pick_valid),
        .index  (w_pick_idx)
    );

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign w_bytes[gi] = bus.data[gi*UART_BYTE_W +: UART_BYTE_W];
    end

    // The owner's req and the FIFO flag gate the write in the same cycle.
    assign w_wr_en      = (r_state == BUSY) && bus.req[r_owner] && !bus.fifo_full;
    assign w_next_ptr   = (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
    assign w_burst_next = (r_burst_cnt == 8'hFF) ? 8'hFF : r_burst_cnt + 8'd1;

    assign bus.fifo_wr_en = w_wr_en;
    assign bus.fifo_data  = w_wr_en ? w_bytes[r_owner] : '0;
    assign bus.ack        = w_wr_en ? (N_REQ'(1) << r_owner) : '0;
    assign bus.grant      = r_grant;
    assign bus.busy       = (r_state == BUSY);
    assign bus.pkt_done   = r_pkt_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_burst_cnt <= '0;
            r_pkt_done  <= 1'b0;
        end else begin
            r_pkt_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_owner     <= w_pick_idx;
                        r_grant     <= N_REQ'(1) << w_pick_idx;
                        r_burst_cnt <= '0;
                        r_state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_wr_en) begin
                        r_burst_cnt <= w_burst_next;
                        if (bus.last[r_owner]) begin
                            r_state    <= IDLE;
                            r_grant    <= '0;
                            r_rr_ptr   <= w_next_ptr;
                            r_pkt_done <= 1'b1;
                        end
`ifdef UART_ARB_BURST_LIMIT_EN
                        // Preempted owner re-arbitrates for the rest of its packet.
                        else if (w_burst_next == 8'(MAX_BURST)) begin
                            r_state  <= IDLE;
                            r_grant  <= '0;
                            r_rr_ptr <= w_next_ptr;
                        end
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter (N_REQ=4,
//               MAX_BURST=4; burst case active with UART_ARB_BURST_LIMIT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   err_cnt = 0;
    int   chk_cnt = 0;
    int   wr_cnt  = 0;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(
        .N_REQ     (N),
        .MAX_BURST (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.fifo_wr_en === 1'b1) wr_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] put(input int i, input logic [7:0] b);
        return 32'(b) << (8 * i);
    endfunction

    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [31:0] d);
        bus.req  = r;
        bus.last = l;
        bus.data = d;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.data      = '0;
        bus.last      = '0;
        bus.fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        to_neg();
        check_eq("rst_grant", 32'(bus.grant), 32'h0);
        check_eq("rst_busy", 32'(bus.busy), 32'h0);
        check_eq("rst_pkt_done", 32'(bus.pkt_done), 32'h0);
        check_eq("rst_ack", 32'(bus.ack), 32'h0);
        check_eq("rst_wr_en", 32'(bus.fifo_wr_en), 32'h0);
        check_eq("rst_fifo_data", 32'(bus.fifo_data), 32'h0);
        check_eq("rst_rr_ptr", 32'(dut.r_rr_ptr), 32'h0);
        to_next();
        rst_n = 1'b1;

        // Requester 1 sends A1 A2 A3
        drive(4'b0010, 4'b0000, put(1, 8'hA1));
        to_neg();
        check_eq("t1_idle_grant", 32'(bus.grant), 32'h0);
        check_eq("t1_idle_wr_en", 32'(bus.fifo_wr_en), 32'h0);
        to_next();
        to_neg();
        check_eq("t1_grant", 32'(bus.grant), 32'h2);
        check_eq("t1_busy", 32'(bus.busy), 32'h1);
        check_eq("t1_byte0", 32'(bus.fifo_data), 32'hA1);
        check_eq("t1_ack0", 32'(bus.ack), 32'h2);
        to_next();
        drive(4'b0010, 4'b0000, put(1, 8'hA2));
        to_neg();
        check_eq("t1_byte1", 32'(bus.fifo_data), 32'hA2);
        to_next();
        drive(4'b0010, 4'b0010, put(1, 8'hA3));
        to_neg();
        check_eq("t1_byte2", 32'(bus.fifo_data), 32'hA3);
        check_eq("t1_ack2", 32'(bus.ack), 32'h2);
        to_next();
        drive(4'b0000, 4'b0000, 32'h0);
        to_neg();
        check_eq("t1_pkt_done", 32'(bus.pkt_done), 32'h1);
        check_eq("t1_end_busy", 32'(bus.busy), 32'h0);
        check_eq("t1_end_grant", 32'(bus.grant), 32'h0);
        check_eq("t1_rr_ptr", 32'(dut.r_rr_ptr), 32'h2);
        check_eq("t1_burst_cnt", 32'(dut.r_burst_cnt), 32'h3);
        to_next();
        to_neg();
        check_eq("t1_pkt_done_once", 32'(bus.pkt_done), 32'h0);

        // Asynchronous reset during a BUSY transfer
        to_next();
        drive(4'b0100, 4'b0000, put(2, 8'h55));
        to_next();
        to_neg();
        check_eq("t5_grant", 32'(bus.grant), 32'h4);
        check_eq("t5_wr_en", 32'(bus.fifo_wr_en), 32'h1);
        to_next();
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_grant", 32'(bus.grant), 32'h0);
        check_eq("t5_rst_busy", 32'(bus.busy), 32'h0);
        check_eq("t5_rst_wr_en", 32'(bus.fifo_wr_en), 32'h0);
        check_eq("t5_rst_ack", 32'(bus.ack), 32'h0);
        check_eq("t5_rst_data", 32'(bus.fifo_data), 32'h0);
        check_eq("t5_rst_pkt_done", 32'(bus.pkt_done), 32'h0);
        check_eq("t5_rst_rr_ptr", 32'(dut.r_rr_ptr), 32'h0);
        to_next();
        rst_n = 1'b1;
        drive(4'b1000, 4'b1000, put(3, 8'h77));
        to_neg();
        check_eq("t5_idle_busy", 32'(bus.busy), 32'h0);
        to_next();
        to_neg();
        check_eq("t5_req3_grant", 32'(bus.grant), 32'h8);
        check_eq("t5_req3_data", 32'(bus.fifo_data), 32'h77);
        to_next();
        drive(4'b0000, 4'b0000, 32'h0);
        to_neg();
        check_eq("t5_pkt_done", 32'(bus.pkt_done), 32'h1);
        check_eq("t5_rr_wrap", 32'(dut.r_rr_ptr), 32'h0);

        // All four requesters stream 1-byte packets: order 0,1,2,3,0
        to_next();
        drive(4'b1111, 4'b1111, 32'h13121110);
        for (int k = 0; k < 5; k++) begin
            to_neg();
            check_eq($sformatf("t2_gap%0d_busy", k), 32'(bus.busy), 32'h0);
            to_next();
            to_neg();
            check_eq($sformatf("t2_svc%0d_grant", k), 32'(bus.grant), 32'(1) << (k % 4));
            check_eq($sformatf("t2_svc%0d_data", k), 32'(bus.fifo_data), 32'h10 + 32'(k % 4));
            to_next();
        end
        drive(4'b0000, 4'b0000, 32'h0);
        to_neg();
        check_eq("t2_rr_ptr", 32'(dut.r_rr_ptr), 32'h1);

        // Owner 1 stalls its req for 2 cycles while requester 2 waits
        to_next();
        drive(4'b0110, 4'b0100, put(1, 8'hB0) | put(2, 8'hBB));
        to_next();
        to_neg();
        check_eq("t4_grant", 32'(bus.grant), 32'h2);
        check_eq("t4_byte0", 32'(bus.fifo_data), 32'hB0);
        check_eq("t4_ack0", 32'(bus.ack), 32'h2);
        to_next();
        drive(4'b0100, 4'b0100, put(2, 8'hBB));
        for (int k = 0; k < 2; k++) begin
            to_neg();
            check_eq($sformatf("t4_stall%0d_grant", k), 32'(bus.grant), 32'h2);
            check_eq($sformatf("t4_stall%0d_ack", k), 32'(bus.ack), 32'h0);
            check_eq($sformatf("t4_stall%0d_wr_en", k), 32'(bus.fifo_wr_en), 32'h0);
            to_next();
        end
        drive(4'b0110, 4'b0110, put(1, 8'hB1) | put(2, 8'hBB));
        to_neg();
        check_eq("t4_last_ack", 32'(bus.ack), 32'h2);
        check_eq("t4_last_data", 32'(bus.fifo_data), 32'hB1);
        to_next();
        drive(4'b0100, 4'b0100, put(2, 8'hBB));
        to_neg();
        check_eq("t4_pkt_done", 32'(bus.pkt_done), 32'h1);
        check_eq("t4_gap_ack", 32'(bus.ack), 32'h0);
        to_next();
        to_neg();
        check_eq("t4_req2_grant", 32'(bus.grant), 32'h4);
        check_eq("t4_req2_data", 32'(bus.fifo_data), 32'hBB);
        to_next();

        // Owner 3 mid-packet with FIFO full for 5 cycles
        drive(4'b1000, 4'b0000, put(3, 8'hC0));
        to_next();
        to_neg();
        check_eq("t3_grant", 32'(bus.grant), 32'h8);
        check_eq("t3_byte0", 32'(bus.fifo_data), 32'hC0);
        to_next();
        wr_cnt = 0;
        drive(4'b1000, 4'b0000, put(3, 8'hC1));
        bus.fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            to_neg();
            check_eq($sformatf("t3_full%0d_wr_en", k), 32'(bus.fifo_wr_en), 32'h0);
            check_eq($sformatf("t3_full%0d_ack", k), 32'(bus.ack), 32'h0);
            check_eq($sformatf("t3_full%0d_grant", k), 32'(bus.grant), 32'h8);
            to_next();
        end
        bus.fifo_full = 1'b0;
        to_neg();
        check_eq("t3_resume_wr_en", 32'(bus.fifo_wr_en), 32'h1);
        check_eq("t3_resume_data", 32'(bus.fifo_data), 32'hC1);
        to_next();
        drive(4'b1000, 4'b1000, put(3, 8'hC2));
        to_neg();
        check_eq("t3_byte2", 32'(bus.fifo_data), 32'hC2);
        to_next();
        drive(4'b0000, 4'b0000, 32'h0);
        to_neg();
        check_eq("t3_write_count", 32'(wr_cnt), 32'h2);
        check_eq("t3_pkt_done", 32'(bus.pkt_done), 32'h1);
        check_eq("t3_rr_ptr", 32'(dut.r_rr_ptr), 32'h0);

`ifdef UART_ARB_BURST_LIMIT_EN
        // Burst limit 4: requester 0 preempted after 4 bytes by requester 1
        to_next();
        drive(4'b0011, 4'b0010, put(0, 8'hD0) | put(1, 8'hE0));
        to_next();
        for (int b = 0; b < 4; b++) begin
            to_neg();
            check_eq($sformatf("bl_grant%0d", b), 32'(bus.grant), 32'h1);
            check_eq($sformatf("bl_byte%0d", b), 32'(bus.fifo_data), 32'hD0 + 32'(b));
            to_next();
            drive(4'b0011, 4'b0010, put(0, 8'hD0 + 8'(b + 1)) | put(1, 8'hE0));
        end
        to_neg();
        check_eq("bl_preempt_busy", 32'(bus.busy), 32'h0);
        check_eq("bl_preempt_no_done", 32'(bus.pkt_done), 32'h0);
        check_eq("bl_preempt_rr_ptr", 32'(dut.r_rr_ptr), 32'h1);
        to_next();
        to_neg();
        check_eq("bl_req1_grant", 32'(bus.grant), 32'h2);
        check_eq("bl_req1_data", 32'(bus.fifo_data), 32'hE0);
        to_next();
        drive(4'b0001, 4'b0000, put(0, 8'hD4));
        to_neg();
        check_eq("bl_req1_done", 32'(bus.pkt_done), 32'h1);
        to_next();
        to_neg();
        check_eq("bl_resume_grant", 32'(bus.grant), 32'h1);
        check_eq("bl_byte4", 32'(bus.fifo_data), 32'hD4);
        to_next();
        drive(4'b0001, 4'b0001, put(0, 8'hD5));
        to_neg();
        check_eq("bl_byte5", 32'(bus.fifo_data), 32'hD5);
        check_eq("bl_ack5", 32'(bus.ack), 32'h1);
        to_next();
        drive(4'b0000, 4'b0000, 32'h0);
        to_neg();
        check_eq("bl_pkt_done", 32'(bus.pkt_done), 32'h1);
        check_eq("bl_rr_ptr", 32'(dut.r_rr_ptr), 32'h1);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmit FIFO among `N_REQ` byte-stream requesters. Transfers are packet-atomic: the owning requester keeps the FIFO write port until its last byte is written. The block sits upstream of the TX FIFO's write port, and the FIFO drains into `uart_tx`. FIFO backpressure is honoured through the FIFO's `full` flag.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `MAX_BURST`, 16: byte limit per grant; used only when `UART_ARB_BURST_LIMIT_EN` is defined. Range 1..255.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, `N_REQ`: requester i has a byte valid on its `data` slice.
- `data`, input, `8*N_REQ`: byte of requester i is `data[8*i+7:8*i]`.
- `last`, input, `N_REQ`: the current byte of requester i ends its packet.
- `ack`, output, `N_REQ`: the byte of requester i is written this cycle; the requester advances on the next edge.
- `grant`, output, `N_REQ`: one-hot owner; all zero when idle.
- `fifo_full`, input, 1: the TX FIFO `full` flag.
- `fifo_wr_en`, output, 1: TX FIFO write enable.
- `fifo_data`, output, 8: TX FIFO write data.
- `busy`, output, 1: the arbiter is in BUSY.
- `pkt_done`, output, 1: one-cycle pulse when a packet completes (the byte with `last` is written).

## Operation
- The FSM has two states: IDLE and BUSY. Registers:
  - `state`
  - `owner` (clog2(`N_REQ`) bits)
  - `rr_ptr` (same width)
  - `grant`
  - `burst_cnt` (8 bits)
- IDLE behaviour:
  - If `req` is non-zero, select the first asserted index scanning `rr_ptr`, `rr_ptr`+1, … (mod `N_REQ`).
  - Register that index into `owner`, set the matching `grant` bit, go to BUSY, and clear `burst_cnt`.
  - If `req` is zero, stay in IDLE.
- BUSY transfer: `fifo_wr_en` = `req[owner]` & !`fifo_full`. It is combinational from registered state plus `req` and `fifo_full`. `ack` = `fifo_wr_en` on bit `owner` only. `fifo_data` = `data` slice of `owner`.
- BUSY, transfer with `last[owner]`:
  - Go to IDLE and clear `grant`.
  - Set `rr_ptr` = (`owner`+1) mod `N_REQ`, wrapping at `N_REQ`-1 → 0, including non-power-of-two `N_REQ`.
  - Pulse `pkt_done`.
- BUSY, `req[owner]` low: hold the grant; the packet stays atomic and no other requester is served. A requester must not abandon a packet.
- `fifo_full` high: no write and no `ack`; all state is held.
- `req` of non-owners is ignored while BUSY, and those requesters get no `ack`.
- `burst_cnt` increments per transfer and saturates at 255 (without the macro it is informational only).

## Timing
- Reset values:
  - `state` = IDLE, `owner` = 0, `rr_ptr` = 0, `grant` = 0, `burst_cnt` = 0.
  - `busy` = 0, `pkt_done` = 0, `ack` = 0, `fifo_wr_en` = 0, `fifo_data` = 0.
- `fifo_data` is zero whenever `fifo_wr_en` is low.
- Arbitration latency: `req` rising in cycle t while IDLE → `grant` and `busy` at t+1 → first write at t+1 if the FIFO is not full.
- Throughput is one byte per cycle while BUSY.
- Packet-to-packet gap is exactly one IDLE cycle.
- A single-byte packet (`last` on the first byte) is legal and occupies one BUSY cycle.
- Asynchronous reset mid-packet aborts immediately. Outputs go to their reset values with no partial-packet recovery; requesters restart packets after reset.
- `fifo_full` deasserting while BUSY allows a write in the same cycle.

## Configuration
- Macro: `UART_ARB_BURST_LIMIT_EN`.
- Defined: a transfer that makes `burst_cnt` reach `MAX_BURST` without `last` forces the arbiter to IDLE. It sets `rr_ptr` = `owner`+1 and does not pulse `pkt_done`. The preempted requester re-arbitrates for the remainder of its packet, so packets may interleave at the FIFO.
- Undefined: no preemption. `MAX_BURST` is unused, and packets are strictly atomic.

## Structure
- Shared package `uart_pkg`: `uart_arb_state_t` enum (IDLE, BUSY) and the `UART_BYTE_W` = 8 constant.
- Sub-module `uart_rr_pick`: combinational rotating-priority picker with inputs `req` and `rr_ptr`, and outputs `valid` and `index`. It is reusable by the RX-side distributors.

## Test plan
- Reset, then `req`=4'b0010 with a 3-byte packet 0xA1, 0xA2, 0xA3 (`last` on 0xA3) → `grant`=0010 one cycle later. `fifo_data` is A1, A2, A3 on consecutive cycles, then `pkt_done` pulses once and `rr_ptr`=2.
- All four requesters send 1-byte packets continuously from `rr_ptr`=0 → service order is 0, 1, 2, 3, 0, with exactly one IDLE cycle between grants.
- Owner 3 mid-packet with `fifo_full` held high for 5 cycles → no `fifo_wr_en` and no `ack` for those 5 cycles. Writes resume in the cycle `fifo_full` drops, and no byte is lost or duplicated.
- Owner 1 drops `req` for 2 cycles mid-packet while `req[2]` is high → `grant` stays 0010 and requester 2 gets no `ack` until requester 1's `last` byte is written.
- Reset asserted during a BUSY transfer → all outputs are 0 asynchronously; after release, `req`=1000 is granted to requester 3 with `rr_ptr` restarted from 0.
- With `UART_ARB_BURST_LIMIT_EN` and `MAX_BURST`=4, requester 0 sends a 6-byte packet while requester 1 is waiting → bytes 0–3 go from requester 0, then requester 1's packet, then requester 0's bytes 4–5.
